// File: rtl/hazard_ctrl.sv
// Hazard controller: operand forwarding, load-use stall, multicycle-EX stall FSM and branch flush.
// Optional performance counters are enabled by defining HAZARD_CTRL_PERF_EN.
module hazard_ctrl #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned MC_LATENCY = 4,
    parameter int unsigned SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC*REG_AW-1:0]   rs_IfId,
    input  logic [NUM_SRC*REG_AW-1:0]   rs_IdEx,
    input  logic [REG_AW-1:0]           rd_IdEx,
    input  logic                        mem_read_IdEx,
    input  logic                        mc_start_IdEx,
    input  logic [FWD_STAGES*REG_AW-1:0] rd_stage,
    input  logic [FWD_STAGES-1:0]       reg_write_stage,
    input  logic                        branch_taken_Ex,
    output logic [NUM_SRC*SEL_W-1:0]    forward_sel,
    output logic                        stall_pc,
    output logic                        stall_IfId,
    output logic                        stall_IdEx,
    output logic                        bubble_IdEx,
    output logic                        bubble_ExMem,
    output logic                        flush_IfId,
    output logic                        flush_IdEx,
    output logic                        mc_busy,
    output logic                        mc_done
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]                 perf_stall_cycles,
    output logic [31:0]                 perf_flush_count,
    output logic [31:0]                 perf_lu_count
`endif
);

    localparam int unsigned CNT_W = $clog2(MC_LATENCY);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic             loadUse;
    logic             mcStall;

    // Forwarding: youngest matching write-back stage wins; x0 never forwards.
    always_comb begin
        forward_sel = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            for (int k = int'(FWD_STAGES) - 1; k >= 0; k--) begin
                if (reg_write_stage[k] &&
                    (rd_stage[k*REG_AW +: REG_AW] == rs_IdEx[i*REG_AW +: REG_AW]) &&
                    (rs_IdEx[i*REG_AW +: REG_AW] != '0)) begin
                    forward_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                end
            end
        end
    end

    // Load-use: load in ID/EX writes a register read by the instruction in IF/ID.
    always_comb begin
        loadUse = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (rs_IfId[i*REG_AW +: REG_AW] == rd_IdEx) begin
                loadUse = 1'b1;
            end
        end
        loadUse = loadUse && mem_read_IdEx && (rd_IdEx != '0) && (state == IDLE);
    end

    // State register and latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Next-state: a taken branch aborts any multicycle op in flight.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        if (branch_taken_Ex) begin
            stateNext = IDLE;
            cntNext   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mc_start_IdEx) begin
                        stateNext = MC_BUSY;
                        cntNext   = CNT_W'(MC_LATENCY - 1);
                    end
                end
                MC_BUSY: begin
                    if (cnt <= CNT_W'(1)) begin
                        stateNext = IDLE;
                        cntNext   = '0;
                    end else begin
                        cntNext = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end
            endcase
        end
    end

    // Outputs: flush > multicycle stall > load-use; all forced low during reset.
    always_comb begin
        stall_pc     = 1'b0;
        stall_IfId   = 1'b0;
        stall_IdEx   = 1'b0;
        bubble_IdEx  = 1'b0;
        bubble_ExMem = 1'b0;
        flush_IfId   = 1'b0;
        flush_IdEx   = 1'b0;
        mc_busy      = 1'b0;
        mc_done      = 1'b0;
        mcStall      = ((state == IDLE) && mc_start_IdEx) ||
                       ((state == MC_BUSY) && (cnt > CNT_W'(1)));
        if (rst_n) begin
            mc_busy = (state == MC_BUSY);
            if (branch_taken_Ex) begin
                flush_IfId = 1'b1;
                flush_IdEx = 1'b1;
            end else begin
                mc_done = (state == MC_BUSY) && (cnt == CNT_W'(1));
                if (mcStall) begin
                    stall_pc     = 1'b1;
                    stall_IfId   = 1'b1;
                    stall_IdEx   = 1'b1;
                    bubble_ExMem = 1'b1;
                end else if (loadUse) begin
                    stall_pc    = 1'b1;
                    stall_IfId  = 1'b1;
                    bubble_IdEx = 1'b1;
                end
            end
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    // Saturating event counters; bubble_IdEx is asserted only by an unmasked load-use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
            perf_lu_count     <= '0;
        end else begin
            if (stall_pc && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (flush_IfId && (perf_flush_count != 32'hFFFF_FFFF)) begin
                perf_flush_count <= perf_flush_count + 32'd1;
            end
            if (bubble_IdEx && (perf_lu_count != 32'hFFFF_FFFF)) begin
                perf_lu_count <= perf_lu_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (default parameters).
// Control vector order: {stall_pc, stall_IfId, stall_IdEx, bubble_IdEx, bubble_ExMem, flush_IfId, flush_IdEx, mc_busy, mc_done}.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rsIfId;
    logic [9:0]  rsIdEx;
    logic [4:0]  rdIdEx;
    logic        memRead;
    logic        mcStart;
    logic [9:0]  rdStage;
    logic [1:0]  weStage;
    logic        branch;
    logic [3:0]  fwdSel;
    logic        stallPc, stallIfId, stallIdEx, bubbleIdEx, bubbleExMem;
    logic        flushIfId, flushIdEx, mcBusy, mcDone;
    logic [8:0]  ctrl;
`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] perfStall, perfFlush, perfLu;
`endif

    int checks = 0;
    int errors = 0;

    assign ctrl = {stallPc, stallIfId, stallIdEx, bubbleIdEx, bubbleExMem,
                   flushIfId, flushIdEx, mcBusy, mcDone};

    hazard_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rs_IfId         (rsIfId),
        .rs_IdEx         (rsIdEx),
        .rd_IdEx         (rdIdEx),
        .mem_read_IdEx   (memRead),
        .mc_start_IdEx   (mcStart),
        .rd_stage        (rdStage),
        .reg_write_stage (weStage),
        .branch_taken_Ex (branch),
        .forward_sel     (fwdSel),
        .stall_pc        (stallPc),
        .stall_IfId      (stallIfId),
        .stall_IdEx      (stallIdEx),
        .bubble_IdEx     (bubbleIdEx),
        .bubble_ExMem    (bubbleExMem),
        .flush_IfId      (flushIfId),
        .flush_IdEx      (flushIdEx),
        .mc_busy         (mcBusy),
        .mc_done         (mcDone)
`ifdef HAZARD_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perfStall),
        .perf_flush_count  (perfFlush),
        .perf_lu_count     (perfLu)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic quiet_inputs();
        rsIfId  = '0;
        rsIdEx  = '0;
        rdIdEx  = '0;
        memRead = 1'b0;
        mcStart = 1'b0;
        rdStage = '0;
        weStage = '0;
        branch  = 1'b0;
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        quiet_inputs();
        rst_n   = 1'b0;
        mcStart = 1'b1;
        memRead = 1'b1;
        rdIdEx  = 5'd7;
        rsIfId  = {5'd0, 5'd7};
        rsIdEx  = {5'd0, 5'd5};
        rdStage = {5'd0, 5'd5};
        weStage = 2'b01;
        #2;
        checks++;
        if (ctrl !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want %b", ctrl, 9'b0);
        end
        checks++;
        if (fwdSel !== 4'b0001) begin
            errors++;
            $display("FAIL reset_fwd_comb: got %b want %b", fwdSel, 4'b0001);
        end
        branch = 1'b1;
        #1;
        checks++;
        if (ctrl !== 9'b0) begin
            errors++;
            $display("FAIL reset_flush_masked: got %b want %b", ctrl, 9'b0);
        end
        quiet_inputs();
        next_cycle();
        #2;
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_forward();
        quiet_inputs();
        rsIdEx  = {5'd3, 5'd5};
        rdStage = {5'd5, 5'd5};
        weStage = 2'b11;
        #1;
        checks++;
        if (fwdSel !== 4'b0001) begin
            errors++;
            $display("FAIL fwd_youngest: got %b want %b", fwdSel, 4'b0001);
        end
        weStage = 2'b10;
        #1;
        checks++;
        if (fwdSel !== 4'b0010) begin
            errors++;
            $display("FAIL fwd_stage1: got %b want %b", fwdSel, 4'b0010);
        end
        rsIdEx  = {5'd0, 5'd0};
        rdStage = {5'd0, 5'd0};
        weStage = 2'b11;
        #1;
        checks++;
        if (fwdSel !== 4'b0000) begin
            errors++;
            $display("FAIL fwd_x0: got %b want %b", fwdSel, 4'b0000);
        end
        rsIdEx  = {5'd9, 5'd4};
        rdStage = {5'd9, 5'd4};
        weStage = 2'b11;
        #1;
        checks++;
        if (fwdSel !== 4'b1001) begin
            errors++;
            $display("FAIL fwd_both_src: got %b want %b", fwdSel, 4'b1001);
        end
        weStage = 2'b00;
        #1;
        checks++;
        if (fwdSel !== 4'b0000) begin
            errors++;
            $display("FAIL fwd_no_we: got %b want %b", fwdSel, 4'b0000);
        end
        quiet_inputs();
    endtask

    task automatic test_load_use();
        quiet_inputs();
        memRead = 1'b1;
        rdIdEx  = 5'd7;
        rsIfId  = {5'd7, 5'd2};
        #1;
        checks++;
        if (ctrl !== 9'b110100000) begin
            errors++;
            $display("FAIL lu_stall: got %b want %b", ctrl, 9'b110100000);
        end
        next_cycle();
        memRead = 1'b0;
        rdIdEx  = 5'd0;
        #1;
        checks++;
        if (ctrl !== 9'b0) begin
            errors++;
            $display("FAIL lu_one_cycle: got %b want %b", ctrl, 9'b0);
        end
        memRead = 1'b1;
        rdIdEx  = 5'd0;
        rsIfId  = {5'd0, 5'd0};
        #1;
        checks++;
        if (ctrl !== 9'b0) begin
            errors++;
            $display("FAIL lu_rd_x0: got %b want %b", ctrl, 9'b0);
        end
        rdIdEx = 5'd7;
        rsIfId = {5'd7, 5'd2};
        branch = 1'b1;
        #1;
        checks++;
        if (ctrl !== 9'b000001100) begin
            errors++;
            $display("FAIL lu_flush_prio: got %b want %b", ctrl, 9'b000001100);
        end
        quiet_inputs();
        next_cycle();
    endtask

    task automatic test_multicycle();
        logic [8:0] expv [0:4];
        expv[0] = 9'b111010000;
        expv[1] = 9'b111010010;
        expv[2] = 9'b111010010;
        expv[3] = 9'b000000011;
        expv[4] = 9'b000000000;
        quiet_inputs();
        mcStart = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) mcStart = 1'b0;
            #1;
            checks++;
            if (ctrl !== expv[c]) begin
                errors++;
                $display("FAIL mc_cycle%0d: got %b want %b", c + 1, ctrl, expv[c]);
            end
            next_cycle();
        end
        quiet_inputs();
    endtask

    task automatic test_branch_abort();
        quiet_inputs();
        mcStart = 1'b1;
        next_cycle();
        next_cycle();
        branch = 1'b1;
        #1;
        checks++;
        if (ctrl !== 9'b000001110) begin
            errors++;
            $display("FAIL br_abort_flush: got %b want %b", ctrl, 9'b000001110);
        end
        next_cycle();
        branch  = 1'b0;
        mcStart = 1'b0;
        #1;
        checks++;
        if (ctrl !== 9'b0) begin
            errors++;
            $display("FAIL br_abort_idle: got %b want %b", ctrl, 9'b0);
        end
        next_cycle();
        #1;
        checks++;
        if (ctrl !== 9'b0) begin
            errors++;
            $display("FAIL br_abort_no_done: got %b want %b", ctrl, 9'b0);
        end
        quiet_inputs();
    endtask

    task automatic test_async_reset();
        quiet_inputs();
        mcStart = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        checks++;
        if (ctrl !== 9'b111010010) begin
            errors++;
            $display("FAIL ar_busy_before: got %b want %b", ctrl, 9'b111010010);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctrl !== 9'b0) begin
            errors++;
            $display("FAIL ar_drop: got %b want %b", ctrl, 9'b0);
        end
        mcStart = 1'b0;
        next_cycle();
        #2;
        rst_n = 1'b1;
        next_cycle();
        #1;
        checks++;
        if (ctrl !== 9'b0) begin
            errors++;
            $display("FAIL ar_idle_after: got %b want %b", ctrl, 9'b0);
        end
        mcStart = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        #1;
        checks++;
        if (ctrl !== 9'b000000011) begin
            errors++;
            $display("FAIL ar_fresh_latency: got %b want %b", ctrl, 9'b000000011);
        end
        mcStart = 1'b0;
        next_cycle();
        quiet_inputs();
    endtask

`ifdef HAZARD_CTRL_PERF_EN
    task automatic test_perf();
        quiet_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        next_cycle();
        mcStart = 1'b1;
        for (int c = 0; c < 4; c++) next_cycle();
        mcStart = 1'b0;
        memRead = 1'b1;
        rdIdEx  = 5'd7;
        rsIfId  = {5'd7, 5'd2};
        next_cycle();
        quiet_inputs();
        branch = 1'b1;
        next_cycle();
        branch = 1'b0;
        next_cycle();
        checks++;
        if (perfStall !== 32'd4) begin
            errors++;
            $display("FAIL perf_stall: got %0d want %0d", perfStall, 4);
        end
        checks++;
        if (perfLu !== 32'd1) begin
            errors++;
            $display("FAIL perf_lu: got %0d want %0d", perfLu, 1);
        end
        checks++;
        if (perfFlush !== 32'd1) begin
            errors++;
            $display("FAIL perf_flush: got %0d want %0d", perfFlush, 1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_multicycle();
        test_branch_abort();
        test_async_reset();
`ifdef HAZARD_CTRL_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
